// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and instruction memory.
interface pc_sequencer_if #(
  parameter int IW = 16
);
  logic          mem_req;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;

  modport master (
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches over req/ack, decodes the opcode and drives
// the PC block (clear, latch strobe, next-PC select, immediate), the regfile
// write strobe and the ALU opcode. Counts retired instructions.
module pc_sequencer #(
  parameter int PC_BITS  = 6,
  parameter int IW       = 16,
  parameter int CNT_BITS = 16
) (
  input  logic                clka,
  input  logic                reset,
  input  logic                run,
  pc_sequencer_if.master      mem,
  input  logic                zero_flag,
  output logic                pc_clear,
  output logic                pc_latch_data,
  output logic [1:0]          pc_ctl,
  output logic [PC_BITS-1:0]  imm,
  output logic [2:0]          rd,
  output logic [2:0]          rs1,
  output logic [2:0]          alu_op,
  output logic                rf_we,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_BITS-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ALU   = 4'h1,
    OP_LOADI = 4'h2,
    OP_BEQZ  = 4'h3,
    OP_JR    = 4'h4,
    OP_JMP   = 4'h5,
    OP_HALT  = 4'hF
  } opcode_e;

  localparam logic [1:0] CTL_INC = 2'b00;
  localparam logic [1:0] CTL_REL = 2'b01;
  localparam logic [1:0] CTL_REG = 2'b10;

  state_e        state;
  state_e        state_nxt;
  logic [IW-1:0] ir;
  logic [3:0]    opcode;
  logic          fetch_req;
  logic          exec_retire;
  logic          exec_illegal;

  assign opcode      = ir[IW-1:IW-4];
  assign mem.mem_req = fetch_req;

  // State register; reset abandons any in-flight fetch.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes; EXEC strobes are gated to legal opcodes.
  always_comb begin
    state_nxt     = state;
    fetch_req     = 1'b0;
    pc_clear      = 1'b0;
    pc_latch_data = 1'b0;
    pc_ctl        = CTL_INC;
    rf_we         = 1'b0;
    halted        = 1'b0;
    exec_retire   = 1'b0;
    exec_illegal  = 1'b0;
    case (state)
      ST_RST: begin
        pc_clear  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (mem.mem_ack) begin
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_NOP: begin
            exec_retire = 1'b1;
          end
          OP_ALU, OP_LOADI: begin
            exec_retire = 1'b1;
            rf_we       = 1'b1;
          end
          OP_BEQZ: begin
            exec_retire = 1'b1;
            pc_ctl      = zero_flag ? CTL_REL : CTL_INC;
          end
          OP_JR: begin
            exec_retire = 1'b1;
            pc_ctl      = CTL_REG;
          end
          OP_JMP: begin
            exec_retire = 1'b1;
            pc_ctl      = CTL_REL;
          end
          OP_HALT: begin
            state_nxt = ST_HALT;
          end
          default: begin
            exec_illegal = 1'b1;
            state_nxt    = ST_HALT;
          end
        endcase
        if (exec_retire) begin
          pc_latch_data = 1'b1;
          state_nxt     = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

  // Instruction register loads on the accepting fetch cycle.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      ir <= '0;
    end else if (state == ST_FETCH && mem.mem_ack) begin
      ir <= mem.mem_rdata;
    end
  end

  // Decoded fields are captured in DECODE and held until the next DECODE.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      imm    <= '0;
      rd     <= '0;
      rs1    <= '0;
      alu_op <= '0;
    end else if (state == ST_DECODE) begin
      imm    <= ir[PC_BITS-1:0];
      rd     <= ir[11:9];
      rs1    <= ir[8:6];
      alu_op <= (opcode == OP_ALU) ? ir[2:0] : 3'b000;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
    end else if (exec_retire) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  // Sticky undefined-opcode flag.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else if (exec_illegal) begin
      illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with an instruction-level
// reference model (counter width reduced to 4 to exercise wrap).
module tb_pc_sequencer;

  localparam int PC_BITS  = 6;
  localparam int IW       = 16;
  localparam int CNT_BITS = 4;

  logic                clka = 1'b0;
  logic                reset = 1'b0;
  logic                run = 1'b0;
  logic                zero_flag = 1'b0;
  logic                pc_clear;
  logic                pc_latch_data;
  logic [1:0]          pc_ctl;
  logic [PC_BITS-1:0]  imm;
  logic [2:0]          rd;
  logic [2:0]          rs1;
  logic [2:0]          alu_op;
  logic                rf_we;
  logic                halted;
  logic                illegal;
  logic [CNT_BITS-1:0] retire_cnt;

  pc_sequencer_if #(.IW(IW)) bus ();

  pc_sequencer #(
    .PC_BITS (PC_BITS),
    .IW      (IW),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clka         (clka),
    .reset        (reset),
    .run          (run),
    .mem          (bus),
    .zero_flag    (zero_flag),
    .pc_clear     (pc_clear),
    .pc_latch_data(pc_latch_data),
    .pc_ctl       (pc_ctl),
    .imm          (imm),
    .rd           (rd),
    .rs1          (rs1),
    .alu_op       (alu_op),
    .rf_we        (rf_we),
    .halted       (halted),
    .illegal      (illegal),
    .retire_cnt   (retire_cnt)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;

  // Reference model state: instructions retired since reset, sticky illegal.
  int   m_retired = 0;
  logic m_illegal = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_cnt();
    return 32'(m_retired % (1 << CNT_BITS));
  endfunction

  function automatic logic [1:0] exp_ctl(input logic [3:0] op, input logic zf);
    case (op)
      4'h3:    return zf ? 2'b01 : 2'b00;
      4'h4:    return 2'b10;
      4'h5:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Full reset; ends at a negedge with the DUT idle and run low.
  task automatic hard_reset();
    reset = 1'b0;
    run = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("rst_clear", pc_clear, 1);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_halt", halted, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_latch", pc_latch_data, 0);
    reset = 1'b1;
    #1;
    chk("rel_clear", pc_clear, 1);
    @(negedge clka);
    chk("rel_clear_drop", pc_clear, 0);
    chk("idle_req", bus.mem_req, 0);
    @(negedge clka);
    chk("idle_stay", bus.mem_req, 0);
    chk("idle_clear", pc_clear, 0);
    m_retired = 0;
    m_illegal = 1'b0;
  endtask

  // From idle, raise run; ends at a negedge in FETCH.
  task automatic go_fetch();
    run = 1'b1;
    @(negedge clka);
    chk("go_req", bus.mem_req, 1);
  endtask

  // Reset while a fetch is outstanding: request must drop at once.
  task automatic abort_fetch();
    bus.mem_ack = 1'b0;
    chk("pre_abort_req", bus.mem_req, 1);
    reset = 1'b0;
    #1;
    chk("abort_req", bus.mem_req, 0);
    chk("abort_clear", pc_clear, 1);
    hard_reset();
  endtask

  // One instruction, entered at a negedge with the DUT in FETCH. Legal
  // instructions leave the DUT in FETCH; HALT/undefined leave it halted.
  task automatic do_instr(input logic [15:0] ins, input int delay,
                          input logic zf, input logic run_next);
    logic [3:0] op;
    logic       legal;
    op = ins[15:12];
    legal = (op <= 4'h5);
    chk("fetch_req", bus.mem_req, 1);
    for (int w = 0; w < delay; w++) begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 16'($urandom);
      run = 1'($urandom_range(0, 1));
      @(negedge clka);
      chk("wait_req", bus.mem_req, 1);
      chk("wait_strobe", {pc_latch_data, rf_we}, 0);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = ins;
    zero_flag = zf;
    run = run_next;
    @(negedge clka);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'($urandom);
    chk("dec_req", bus.mem_req, 0);
    chk("dec_strobe", {pc_latch_data, rf_we}, 0);
    chk("dec_ctl", pc_ctl, 0);
    @(negedge clka);
    chk("exec_latch", pc_latch_data, legal);
    chk("exec_we", rf_we, (op == 4'h1 || op == 4'h2));
    if (legal) chk("exec_ctl", pc_ctl, exp_ctl(op, zf));
    chk("exec_imm", imm, ins[PC_BITS-1:0]);
    chk("exec_rd", rd, ins[11:9]);
    chk("exec_rs1", rs1, ins[8:6]);
    chk("exec_alu", alu_op, (op == 4'h1) ? ins[2:0] : 3'b000);
    chk("exec_cnt", retire_cnt, m_cnt());
    chk("exec_req", bus.mem_req, 0);
    chk("exec_halt", halted, 0);
    chk("exec_ill", illegal, m_illegal);
    @(negedge clka);
    chk("post_latch", pc_latch_data, 0);
    chk("post_we", rf_we, 0);
    if (legal) begin
      m_retired++;
      chk("retire_cnt", retire_cnt, m_cnt());
      chk("post_halt", halted, 0);
      if (run_next) begin
        chk("next_fetch", bus.mem_req, 1);
      end else begin
        chk("stop_idle", bus.mem_req, 0);
        @(negedge clka);
        chk("idle_hold", bus.mem_req, 0);
        run = 1'b1;
        @(negedge clka);
        chk("resume_req", bus.mem_req, 1);
      end
    end else begin
      if (op != 4'hF) m_illegal = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk("halt_flag", halted, 1);
        chk("halt_ill", illegal, m_illegal);
        chk("halt_cnt", retire_cnt, m_cnt());
        chk("halt_req", bus.mem_req, 0);
        chk("halt_latch", pc_latch_data, 0);
        run = ~run;
        @(negedge clka);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] ins;
    int          r;
    int          dly;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    // Boot, then reset while a fetch is pending.
    hard_reset();
    go_fetch();
    abort_fetch();
    go_fetch();

    // ALU with single-cycle fetch, then BEQZ taken and not taken.
    do_instr(16'h1005, 0, 1'b0, 1'b1);
    do_instr(16'h3006, 0, 1'b1, 1'b1);
    do_instr(16'h3006, 1, 1'b0, 1'b1);

    // Slow fetch with run dropped while waiting; ends idle then resumes.
    do_instr(16'h0000, 4, 1'b0, 1'b0);

    // Counter wrap and JR.
    for (int i = 0; i < 17; i++) do_instr(16'h0000, 0, 1'b0, 1'b1);
    do_instr(16'h4040, 0, 1'b0, 1'b1);

    // HALT, then undefined opcode.
    do_instr(16'hF000, 0, 1'b0, 1'b1);
    hard_reset();
    go_fetch();
    do_instr(16'h9000, 2, 1'b0, 1'b1);
    hard_reset();
    go_fetch();

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 90)      op = 4'($urandom_range(0, 5));
      else if (r < 95) op = 4'hF;
      else             op = 4'($urandom_range(6, 14));
      ins = {op, 12'($urandom)};
      dly = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2));
      do_instr(ins, dly, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      if (op > 4'h5) begin
        hard_reset();
        go_fetch();
      end else if ($urandom_range(0, 39) == 0) begin
        abort_fetch();
        go_fetch();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
